// File: rtl/vx_ttu_req_arbiter_pkg.sv
// Shared types for the TTU request arbiter: FSM states, completion status, width helper.
package vx_ttu_req_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STATUS_W = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_BUSY  = 2'd2,
    ARB_RESP  = 2'd3
  } ttu_arb_state_t;

  typedef enum logic [STATUS_W-1:0] {
    TTU_ARB_OK        = 2'd0,
    TTU_ARB_NOT_FOUND = 2'd1,
    TTU_ARB_TIMEOUT   = 2'd2
  } ttu_arb_status_t;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_ttu_req_arbiter_if.sv
// Requester-side and IRQC-side signals of the TTU request arbiter.
interface vx_ttu_req_arbiter_if
  import vx_ttu_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned WID_W    = 2,
  parameter int unsigned TID_W    = 3
);

  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0]            req_ready;
  logic [NUM_REQS-1:0][WID_W-1:0] req_wid;
  logic [NUM_REQS-1:0][TID_W-1:0] req_tid;
  logic [NUM_REQS-1:0][XLEN-1:0]  req_isr_pc;
  logic [NUM_REQS-1:0]            rsp_valid;
  ttu_arb_status_t                rsp_status;

  logic                           irq_valid;
  logic                           irq_ready;
  logic [WID_W-1:0]               irq_wid;
  logic [TID_W-1:0]               irq_tid;
  logic [XLEN-1:0]                irq_pc;
  logic                           irq_done;
  logic                           irq_not_found;
  logic                           irq_cancel;
  logic                           busy;

  // Environment view: requesters plus IRQC.
  modport master (
    output req_valid, req_wid, req_tid, req_isr_pc, irq_ready, irq_done, irq_not_found,
    input  req_ready, rsp_valid, rsp_status, irq_valid, irq_wid, irq_tid, irq_pc,
           irq_cancel, busy
  );

  // Arbiter view.
  modport slave (
    input  req_valid, req_wid, req_tid, req_isr_pc, irq_ready, irq_done, irq_not_found,
    output req_ready, rsp_valid, rsp_status, irq_valid, irq_wid, irq_tid, irq_pc,
           irq_cancel, busy
  );

endinterface

// File: rtl/vx_ttu_req_arbiter_rr_pick.sv
// Rotating-priority picker: first valid requester at or after the pointer, wrapping.
module vx_ttu_req_arbiter_rr_pick
  import vx_ttu_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic [NUM_REQS-1:0]         i_req_valid,
  input  logic [log2up(NUM_REQS)-1:0] i_rr_ptr,
  output logic [NUM_REQS-1:0]         o_grant_c,
  output logic [log2up(NUM_REQS)-1:0] o_idx_c,
  output logic                        o_any_c
);

  localparam int unsigned IDX_W = log2up(NUM_REQS);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      w_cand = IDX_W'((32'(i_rr_ptr) + k) % NUM_REQS);
      if (!o_any_c && i_req_valid[w_cand]) begin
        o_any_c = 1'b1;
        o_idx_c = w_cand;
      end
    end
    if (o_any_c) o_grant_c[o_idx_c] = 1'b1;
  end

endmodule

// File: rtl/vx_ttu_req_arbiter.sv
// Round-robin arbiter feeding thread-transfer requests to IRQC one at a time.
// Optional BUSY watchdog with irq_cancel: define VX_TTU_ARB_TIMEOUT_EN.
module vx_ttu_req_arbiter
  import vx_ttu_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS       = 2,
  parameter int unsigned WARP_CNT       = 4,
  parameter int unsigned THREAD_CNT     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset_n,
  vx_ttu_req_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = log2up(NUM_REQS);
  localparam int unsigned WID_W = log2up(WARP_CNT);
  localparam int unsigned TID_W = log2up(THREAD_CNT);

  ttu_arb_state_t      r_state, w_state_nxt;
  ttu_arb_status_t     r_status, w_status_nxt;
  logic [IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [IDX_W-1:0]    r_gnt_idx, w_gnt_idx_nxt;
  logic [WID_W-1:0]    r_wid, w_wid_nxt;
  logic [TID_W-1:0]    r_tid, w_tid_nxt;
  logic [XLEN-1:0]     r_pc, w_pc_nxt;
  logic [NUM_REQS-1:0] r_rsp_valid, w_rsp_valid_nxt;
  logic                r_irq_valid, r_busy, r_irq_cancel, w_irq_cancel_nxt;
  logic [NUM_REQS-1:0] w_req_ready_c;
  logic [NUM_REQS-1:0] w_grant_c;
  logic [IDX_W-1:0]    w_pick_idx_c;
  logic                w_any_c;
  logic                w_expire;

  vx_ttu_req_arbiter_rr_pick #(.NUM_REQS(NUM_REQS)) u_rr_pick (
    .i_req_valid (bus.req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_c   (w_grant_c),
    .o_idx_c     (w_pick_idx_c),
    .o_any_c     (w_any_c)
  );

`ifdef VX_TTU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

  // w_cnt_inc is the number of BUSY cycles including the current one.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_expire  = (r_state == ARB_BUSY) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == ARB_ISSUE)     w_cnt_nxt = '0;
    else if (r_state == ARB_BUSY) w_cnt_nxt = w_cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end
`else
  // Watchdog compiled out: BUSY waits on IRQC indefinitely.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_expire         = 1'b0;
`endif

  // Next state, latches and next registered outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_status_nxt     = TTU_ARB_OK;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_gnt_idx_nxt    = r_gnt_idx;
    w_wid_nxt        = r_wid;
    w_tid_nxt        = r_tid;
    w_pc_nxt         = r_pc;
    w_irq_cancel_nxt = 1'b0;
    w_req_ready_c    = '0;
    w_rsp_valid_nxt  = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_c) begin
          w_req_ready_c = w_grant_c;
          w_gnt_idx_nxt = w_pick_idx_c;
          w_wid_nxt     = bus.req_wid[w_pick_idx_c];
          w_tid_nxt     = bus.req_tid[w_pick_idx_c];
          w_pc_nxt      = bus.req_isr_pc[w_pick_idx_c];
          w_rr_ptr_nxt  = IDX_W'((32'(w_pick_idx_c) + 1) % NUM_REQS);
          w_state_nxt   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bus.irq_ready) w_state_nxt = ARB_BUSY;
      end
      ARB_BUSY: begin
        // IRQC completion outranks the watchdog firing in the same cycle.
        if (bus.irq_done) begin
          w_state_nxt  = ARB_RESP;
          w_status_nxt = TTU_ARB_OK;
        end else if (bus.irq_not_found) begin
          w_state_nxt  = ARB_RESP;
          w_status_nxt = TTU_ARB_NOT_FOUND;
        end else if (w_expire) begin
          w_state_nxt      = ARB_RESP;
          w_status_nxt     = TTU_ARB_TIMEOUT;
          w_irq_cancel_nxt = 1'b1;
        end
      end
      ARB_RESP: begin
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
    if (w_state_nxt == ARB_RESP) w_rsp_valid_nxt[r_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ARB_IDLE;
      r_status     <= TTU_ARB_OK;
      r_rr_ptr     <= '0;
      r_gnt_idx    <= '0;
      r_wid        <= '0;
      r_tid        <= '0;
      r_pc         <= '0;
      r_rsp_valid  <= '0;
      r_irq_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_irq_cancel <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_status     <= w_status_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_gnt_idx    <= w_gnt_idx_nxt;
      r_wid        <= w_wid_nxt;
      r_tid        <= w_tid_nxt;
      r_pc         <= w_pc_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_irq_valid  <= (w_state_nxt == ARB_ISSUE);
      r_busy       <= (w_state_nxt != ARB_IDLE);
      r_irq_cancel <= w_irq_cancel_nxt;
    end
  end

  assign bus.req_ready  = w_req_ready_c;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_status = r_status;
  assign bus.irq_valid  = r_irq_valid;
  assign bus.irq_wid    = r_wid;
  assign bus.irq_tid    = r_tid;
  assign bus.irq_pc     = r_pc;
  assign bus.irq_cancel = r_irq_cancel;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_vx_ttu_req_arbiter.sv
// Scoreboard bench for vx_ttu_req_arbiter; builds with or without VX_TTU_ARB_TIMEOUT_EN.
module tb_vx_ttu_req_arbiter;
  import vx_ttu_req_arbiter_pkg::*;

  localparam int unsigned NR    = 2;
  localparam int unsigned WID_W = 2;
  localparam int unsigned TID_W = 3;
  localparam int unsigned TO    = 16;
`ifdef VX_TTU_ARB_TIMEOUT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  typedef struct {
    logic [WID_W-1:0] wid;
    logic [TID_W-1:0] tid;
    logic [XLEN-1:0]  pc;
  } irq_exp_t;

  typedef struct {
    int unsigned idx;
    logic [1:0]  status;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  irq_exp_t    q_irq[$];
  rsp_exp_t    q_rsp[$];
  int unsigned grant_log[$];
  irq_exp_t    m_irq;
  rsp_exp_t    m_rsp;
  int unsigned n_pass = 0;
  int unsigned n_checks = 0;
  int unsigned m_rr = 0;

  always #5 clk = ~clk;

  vx_ttu_req_arbiter_if #(.NUM_REQS(NR), .WID_W(WID_W), .TID_W(TID_W)) bus ();

  vx_ttu_req_arbiter #(
    .NUM_REQS(NR), .WARP_CNT(4), .THREAD_CNT(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard pops: IRQC handshake fields and completion pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.irq_valid && bus.irq_ready) begin
        check("irq_expected", 64'(q_irq.size() != 0), 64'(1));
        if (q_irq.size() != 0) begin
          m_irq = q_irq.pop_front();
          check("irq_wid", 64'(bus.irq_wid), 64'(m_irq.wid));
          check("irq_tid", 64'(bus.irq_tid), 64'(m_irq.tid));
          check("irq_pc",  64'(bus.irq_pc),  64'(m_irq.pc));
        end
      end
      if (|bus.rsp_valid) begin
        check("rsp_expected", 64'(q_rsp.size() != 0), 64'(1));
        if (q_rsp.size() != 0) begin
          m_rsp = q_rsp.pop_front();
          check("rsp_valid",  64'(bus.rsp_valid),  64'(1) << m_rsp.idx);
          check("rsp_status", 64'(bus.rsp_status), 64'(m_rsp.status));
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.irq_ready = 1'b0;
    bus.irq_done = 1'b0;
    bus.irq_not_found = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    q_irq.delete();
    q_rsp.delete();
    grant_log.delete();
    m_rr = 0;
  endtask

  // kind: 0 done, 1 not_found, 2 done+not_found, 3 no answer (watchdog / wait).
  task automatic do_txn(input logic [NR-1:0] mask, input bit hold, input int unsigned ready_delay,
                        input int unsigned busy_len, input int unsigned kind, input bit abort);
    int unsigned g;
    bit found;
    bit got;
    bit saw_cancel;
    int unsigned cnt;
    irq_exp_t ei;
    rsp_exp_t er;
    g = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      int unsigned i;
      i = (m_rr + k) % NR;
      if (!found && mask[i]) begin
        g = i;
        found = 1'b1;
      end
    end
    m_rr = (g + 1) % NR;
    grant_log.push_back(g);
    ei.wid = bus.req_wid[g];
    ei.tid = bus.req_tid[g];
    ei.pc  = bus.req_isr_pc[g];
    q_irq.push_back(ei);
    er.idx = g;
    if (kind == 1)                er.status = TTU_ARB_NOT_FOUND;
    else if (kind == 3 && WDT_ON) er.status = TTU_ARB_TIMEOUT;
    else                          er.status = TTU_ARB_OK;
    if (!abort) q_rsp.push_back(er);

    @(posedge clk); #1;
    bus.req_valid = mask;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (|bus.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_seen", 64'(got), 64'(1));
    if (!got) begin
      bus.req_valid = '0;
      return;
    end
    check("req_ready", 64'(bus.req_ready), 64'(1) << g);
    @(posedge clk); #1;
    if (!hold) bus.req_valid = '0;

    for (int c = 0; c < int'(ready_delay); c++) begin
      @(negedge clk);
      check("issue_valid",    64'(bus.irq_valid), 64'(1));
      check("issue_hold_wid", 64'(bus.irq_wid),   64'(ei.wid));
      check("issue_hold_pc",  64'(bus.irq_pc),    64'(ei.pc));
      check("issue_no_ready", 64'(bus.req_ready), 64'(0));
      @(posedge clk); #1;
    end
    bus.irq_ready = 1'b1;
    @(negedge clk);
    check("issue_valid", 64'(bus.irq_valid), 64'(1));
    @(posedge clk); #1;
    bus.irq_ready = 1'b0;

    for (int c = 0; c < int'(busy_len); c++) begin
      @(negedge clk);
      check("busy_flag",     64'(bus.busy),      64'(1));
      check("busy_irq_idle", 64'(bus.irq_valid), 64'(0));
      @(posedge clk); #1;
    end

    if (abort) begin
      reset_n = 1'b0;
      bus.req_valid = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      q_irq.delete();
      q_rsp.delete();
      m_rr = 0;
      @(negedge clk);
      check("rst_busy",      64'(bus.busy),      64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_irq_valid", 64'(bus.irq_valid), 64'(0));
      return;
    end

    case (kind)
      0: bus.irq_done = 1'b1;
      1: bus.irq_not_found = 1'b1;
      2: begin
        bus.irq_done = 1'b1;
        bus.irq_not_found = 1'b1;
      end
      default: ;
    endcase
    if (kind == 3) begin
`ifdef VX_TTU_ARB_TIMEOUT_EN
      cnt = 0;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if (bus.irq_cancel) break;
        cnt++;
      end
      check("wdt_busy_cycles", 64'(cnt), 64'(TO));
`else
      saw_cancel = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        saw_cancel = saw_cancel | bus.irq_cancel;
      end
      check("nowdt_still_busy", 64'(bus.busy),   64'(1));
      check("nowdt_no_cancel",  64'(saw_cancel), 64'(0));
      @(posedge clk); #1;
      bus.irq_done = 1'b1;
      @(posedge clk); #1;
      bus.irq_done = 1'b0;
      @(negedge clk);
`endif
    end else begin
      @(posedge clk); #1;
      bus.irq_done = 1'b0;
      bus.irq_not_found = 1'b0;
      @(negedge clk);
    end
    check("resp_cancel", 64'(bus.irq_cancel), 64'(kind == 3 && WDT_ON));
    @(posedge clk); #1;
    @(negedge clk);
    check("rsp_one_cycle",    64'(bus.rsp_valid),  64'(0));
    check("idle_not_busy",    64'(bus.busy),       64'(0));
    check("cancel_one_cycle", 64'(bus.irq_cancel), 64'(0));
    bus.req_valid = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int unsigned exp_order[5];
    exp_order = '{0, 1, 0, 1, 0};
    bus.req_valid = '0;
    bus.irq_ready = 1'b0;
    bus.irq_done = 1'b0;
    bus.irq_not_found = 1'b0;
    bus.req_wid[0] = 2'd3;
    bus.req_tid[0] = 3'd5;
    bus.req_isr_pc[0] = 32'h8000_0100;
    bus.req_wid[1] = 2'd1;
    bus.req_tid[1] = 3'd2;
    bus.req_isr_pc[1] = 32'h8000_0200;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy",       64'(bus.busy),       64'(0));
    check("reset_irq_valid",  64'(bus.irq_valid),  64'(0));
    check("reset_rsp_valid",  64'(bus.rsp_valid),  64'(0));
    check("reset_req_ready",  64'(bus.req_ready),  64'(0));
    check("reset_irq_pc",     64'(bus.irq_pc),     64'(0));
    check("reset_irq_cancel", 64'(bus.irq_cancel), 64'(0));
    check("reset_rsp_status", 64'(bus.rsp_status), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single request, IRQC ready immediately, done after 10 BUSY cycles.
    do_txn(2'b01, 1'b0, 0, 10, 0, 1'b0);

    // Fairness with both requesters asserting.
    apply_reset();
    for (int t = 0; t < 5; t++) do_txn(2'b11, 1'b1, 0, 1, 0, 1'b0);
    for (int t = 0; t < 5; t++) check("rr_order", 64'(grant_log[t]), 64'(exp_order[t]));

    // Not-found, then done and not-found together.
    bus.req_wid[1] = 2'd2;
    bus.req_tid[1] = 3'd7;
    bus.req_isr_pc[1] = 32'h8000_0300;
    do_txn(2'b10, 1'b0, 2, 3, 1, 1'b0);
    do_txn(2'b01, 1'b0, 1, 2, 2, 1'b0);

    // IRQC backpressure for 7 cycles with both requesters waiting.
    do_txn(2'b11, 1'b1, 7, 2, 0, 1'b0);

    // Reset during BUSY; pointer returns to requester 0.
    do_txn(2'b01, 1'b0, 0, 3, 0, 1'b1);
    do_txn(2'b11, 1'b0, 0, 1, 0, 1'b0);

    // No answer from IRQC.
    do_txn(2'b10, 1'b0, 0, 0, 3, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_irq_drained", 64'(q_irq.size()), 64'(0));
    check("sb_rsp_drained", 64'(q_rsp.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
